matmul_mem_ctrl: RTL and testbench

- Responder and host-side sequencer for the matrix-multiply accelerator's memory port.
- Owns the 64 KB shared scratchpad: dimension registers, A/B/C regions and C write-protection.
- Lets the host load operands, validates the dimensions, drives mm_run, waits for mm_int, then raises irq for the host to collect C.
- Sits between the system bus slave wrapper and the accelerator.

---
 rtl/matmul_pkg.sv | 35 +++
 rtl/matmul_sram.sv | 28 ++
 rtl/matmul_mem_ctrl.sv | 160 ++++++++++++++++
 tb/tb_matmul_mem_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and address map for the matrix-multiply memory controller.
// Covers the controller state, scratchpad region bases and error codes.
package matmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic [15:0] DIM_ROWA_ADDR = 16'h0000;
  localparam logic [15:0] DIM_COLA_ADDR = 16'h0004;
  localparam logic [15:0] DIM_COLB_ADDR = 16'h0008;
  localparam logic [15:0] A_BASE        = 16'h1000;
  localparam logic [15:0] B_BASE        = 16'h6000;
  localparam logic [15:0] C_BASE        = 16'hA000;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_DIMS     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_ACCEL_WR = 2'd3;

  localparam int SRAM_WORDS = 16384;

  // Byte offsets within a word never select a different register or word.
  function automatic logic [15:0] word_of(input logic [15:0] addr);
    return {addr[15:2], 2'b00};
  endfunction

  function automatic logic is_sram(input logic [15:0] addr);
    return addr >= A_BASE;
  endfunction

endpackage

// File: rtl/matmul_sram.sv
// 16384x32 single-port scratchpad with one cycle of read latency.
// Read data changes only on a read access; a write leaves it untouched.
module matmul_sram
  import matmul_pkg::*;
#(
  parameter int DEPTH = SRAM_WORDS
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  // NOTE: the array and its read register stay unreset so this maps onto a
  // RAM macro; sequential state is written with <= so every reader sees the
  // pre-edge value.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/matmul_mem_ctrl.sv
// Scratchpad owner and run sequencer for the matrix-multiply accelerator.
// Host owns the SRAM in IDLE/DONE, the accelerator owns it in CHECK/RUN.
module matmul_mem_ctrl
  import matmul_pkg::*;
#(
  parameter int DIM_W       = 8,
  parameter int TIMEOUT_CYC = 2**20,
  parameter int A_WORDS     = 5120,
  parameter int B_WORDS     = 4096,
  parameter int C_WORDS     = 6144
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mm_run,
  input  logic [15:0] mm_addr,
  input  logic        mm_wen,
  input  logic [31:0] mm_wdata,
  output logic [31:0] mm_rdata,
  input  logic        mm_int,
  input  logic        h_req,
  input  logic        h_wen,
  input  logic [15:0] h_addr,
  input  logic [31:0] h_wdata,
  output logic        h_ready,
  output logic        h_rvalid,
  output logic [31:0] h_rdata,
  input  logic        h_start,
  input  logic        h_irq_clr,
  output logic        busy,
  output logic        irq,
  output logic [1:0]  err
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [31:0]     A_LIM    = 32'(A_WORDS);
  localparam logic [31:0]     B_LIM    = 32'(B_WORDS);
  localparam logic [31:0]     C_LIM    = 32'(C_WORDS);

  state_t             state, state_nx;
  logic [DIM_W-1:0]   row_a, col_a, col_b;
  logic [CNT_W-1:0]   cnt;
  logic [2*DIM_W-1:0] prod_a, prod_b, prod_c;
  logic               dims_bad;

  logic        host_own, host_acc, host_rd, dim_wr;
  logic        acc_rd, acc_wr_ok, acc_wr_bad;
  logic [15:0] sel_addr;
  logic        sram_en, sram_we;
  logic [31:0] sram_wdata, sram_q;
  logic [31:0] flop_val, rd_flop, rd_data;
  logic        rd_sram, rd_mm;

  assign host_own   = (state == ST_IDLE) || (state == ST_DONE);
  assign host_acc   = h_req && host_own;
  assign host_rd    = host_acc && !h_wen;
  assign dim_wr     = host_acc && h_wen && (state == ST_IDLE);
  assign acc_rd     = !host_own && !mm_wen;
  assign acc_wr_ok  = (state == ST_RUN) && mm_wen && (mm_addr >= C_BASE);
  assign acc_wr_bad = (state == ST_RUN) && mm_wen && (mm_addr < C_BASE);

  assign sel_addr   = host_own ? h_addr : mm_addr;
  assign sram_we    = host_own ? h_wen : acc_wr_ok;
  assign sram_wdata = host_own ? h_wdata : mm_wdata;
  assign sram_en    = is_sram(sel_addr) && (host_own ? host_acc : (acc_rd || acc_wr_ok));

  matmul_sram u_sram (
    .clk   (clk),
    .en    (sram_en),
    .we    (sram_we),
    .addr  (sel_addr[15:2]),
    .wdata (sram_wdata),
    .rdata (sram_q)
  );

  // Products keep full 2*DIM_W width so large dimensions cannot wrap past a limit.
  assign prod_a   = row_a * col_a;
  assign prod_b   = col_a * col_b;
  assign prod_c   = row_a * col_b;
  assign dims_bad = (row_a == '0) || (col_a == '0) || (col_b == '0) ||
                    (32'(prod_a) > A_LIM) || (32'(prod_b) > B_LIM) ||
                    (32'(prod_c) > C_LIM);

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    flop_val = '0;
    case (word_of(sel_addr))
      DIM_ROWA_ADDR: flop_val = 32'(row_a);
      DIM_COLA_ADDR: flop_val = 32'(col_a);
      DIM_COLB_ADDR: flop_val = 32'(col_b);
      default:       flop_val = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (h_start) state_nx = ST_CHECK;
      ST_CHECK: state_nx = dims_bad ? ST_DONE : ST_RUN;
      ST_RUN:   if (mm_int || (cnt == CNT_LAST)) state_nx = ST_DONE;
      ST_DONE:  if (h_irq_clr) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      err   <= ERR_OK;
      row_a <= '0;
      col_a <= '0;
      col_b <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state == ST_RUN) ? cnt + 1'b1 : '0;
      if (dim_wr) begin
        case (word_of(h_addr))
          DIM_ROWA_ADDR: row_a <= h_wdata[DIM_W-1:0];
          DIM_COLA_ADDR: col_a <= h_wdata[DIM_W-1:0];
          DIM_COLB_ADDR: col_b <= h_wdata[DIM_W-1:0];
          default: ;
        endcase
      end
      // An illegal accelerator write is sticky and outranks a later timeout.
      if (state == ST_CHECK && dims_bad) begin
        err <= ERR_DIMS;
      end else if (acc_wr_bad) begin
        err <= ERR_ACCEL_WR;
      end else if (state == ST_RUN && !mm_int && cnt == CNT_LAST && err != ERR_ACCEL_WR) begin
        err <= ERR_TIMEOUT;
      end else if (state == ST_DONE && h_irq_clr) begin
        err <= ERR_OK;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_rvalid <= 1'b0;
      rd_mm    <= 1'b0;
      rd_sram  <= 1'b0;
      rd_flop  <= '0;
    end else begin
      h_rvalid <= host_rd;
      rd_mm    <= acc_rd;
      rd_sram  <= (host_rd || acc_rd) && is_sram(sel_addr);
      rd_flop  <= flop_val;
    end
  end

  assign rd_data  = rd_sram ? sram_q : rd_flop;
  assign h_rdata  = h_rvalid ? rd_data : '0;
  assign mm_rdata = rd_mm ? rd_data : '0;
  assign h_ready  = host_acc;
  assign mm_run   = (state == ST_RUN);
  assign busy     = (state == ST_CHECK) || (state == ST_RUN);
  assign irq      = (state == ST_DONE);

endmodule

// File: tb/tb_matmul_mem_ctrl.sv
// Self-checking bench for matmul_mem_ctrl: table-driven host map checks plus
// an accelerator model for run, error, timeout and reset sequences.
module tb_matmul_mem_ctrl;

  localparam int          TO  = 64;
  localparam logic [15:0] A_B = 16'h1000;
  localparam logic [15:0] B_B = 16'h6000;
  localparam logic [15:0] C_B = 16'hA000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mm_run, mm_wen = 1'b0, mm_int = 1'b0;
  logic [15:0] mm_addr = '0;
  logic [31:0] mm_wdata = '0, mm_rdata;
  logic        h_req = 1'b0, h_wen = 1'b0, h_start = 1'b0, h_irq_clr = 1'b0;
  logic [15:0] h_addr = '0;
  logic [31:0] h_wdata = '0, h_rdata;
  logic        h_ready, h_rvalid, busy, irq;
  logic [1:0]  err;

  matmul_mem_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .mm_run(mm_run), .mm_addr(mm_addr), .mm_wen(mm_wen),
    .mm_wdata(mm_wdata), .mm_rdata(mm_rdata), .mm_int(mm_int), .h_req(h_req),
    .h_wen(h_wen), .h_addr(h_addr), .h_wdata(h_wdata), .h_ready(h_ready),
    .h_rvalid(h_rvalid), .h_rdata(h_rdata), .h_start(h_start),
    .h_irq_clr(h_irq_clr), .busy(busy), .irq(irq), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          run_total = 0;
  int          rv_total = 0;
  int          rv_expected = 0;
  int          w, run_snap;
  logic [31:0] exp_q[$];
  logic [31:0] a_mem[12];
  logic [31:0] b_mem[6];
  logic [31:0] c_exp[8];
  vec_t        vecs[17];

  always @(negedge clk) begin
    if (mm_run)   run_total++;
    if (h_rvalid) rv_total++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic host_acc(input string name, input logic wen, input logic [15:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp, output int waited);
    waited = 0;
    @(negedge clk);
    h_req = 1'b1; h_wen = wen; h_addr = addr; h_wdata = wdata;
    #1;
    while (!h_ready && waited < 200) begin
      @(negedge clk); #1;
      waited++;
    end
    if (!h_ready) begin
      check({name, "_ready_timeout"}, 32'(h_ready), 32'd1);
      h_req = 1'b0;
      return;
    end
    if (!wen) begin
      exp_q.push_back(exp);
      rv_expected++;
    end
    @(posedge clk); #1;
    h_req = 1'b0; h_wen = 1'b0;
    if (!wen) begin
      @(negedge clk);
      check({name, "_rvalid"}, 32'(h_rvalid), 32'd1);
      check(name, h_rdata, exp_q.pop_front());
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); h_start = 1'b1;
    @(posedge clk); #1; h_start = 1'b0;
  endtask

  task automatic irq_clear(input string name);
    @(negedge clk); h_irq_clr = 1'b1;
    @(posedge clk); #1; h_irq_clr = 1'b0;
    @(negedge clk);
    check({name, "_irq"}, 32'(irq), 32'd0);
    check({name, "_err"}, 32'(err), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic set_dims(input logic [31:0] ra, input logic [31:0] ca, input logic [31:0] cb);
    int wt;
    host_acc("wr_rowa", 1'b1, 16'h0000, ra, '0, wt);
    host_acc("wr_cola", 1'b1, 16'h0004, ca, '0, wt);
    host_acc("wr_colb", 1'b1, 16'h0008, cb, '0, wt);
  endtask

  // Accelerator model: writes C, probes read latency, optionally writes into A, then raises mm_int.
  task automatic accel_run(input int int_at, input bit bad_wr, input logic [1:0] exp_err);
    int waited = 0;
    bit run_ok = 1'b1;
    while (!mm_run && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (!mm_run) begin
      check("accel_run_start", 32'(mm_run), 32'd1);
      return;
    end
    for (int c = 1; c <= int_at; c++) begin
      if (!mm_run) run_ok = 1'b0;
      mm_wen = 1'b0;
      if (c <= 8) begin
        mm_addr = C_B + 16'(4 * (c - 1)); mm_wdata = c_exp[c-1]; mm_wen = 1'b1;
      end else if (c == 9) begin
        mm_addr = A_B;
      end else if (c == 10) begin
        check("mm_rd_a0", mm_rdata, a_mem[0]);
        mm_addr = 16'h0004;
      end else if (c == 11) begin
        check("mm_rd_cola", mm_rdata, 32'd3);
      end else if (c == 12 && bad_wr) begin
        mm_addr = 16'h2000; mm_wdata = 32'hDEAD_BEEF; mm_wen = 1'b1;
      end else if (c == 14 && bad_wr) begin
        check("err3_during_run", 32'(err), 32'd3);
        check("run_continues", 32'(mm_run), 32'd1);
      end
      mm_int = (c == int_at);
      @(negedge clk);
    end
    mm_int = 1'b0; mm_wen = 1'b0;
    check("run_held", 32'(run_ok), 32'd1);
    check("run_dropped", 32'(mm_run), 32'd0);
    check("done_irq", 32'(irq), 32'd1);
    check("done_err", 32'(err), 32'(exp_err));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 12; i++) a_mem[i] = 32'(i * 7 + 1);
    for (int i = 0; i < 6; i++)  b_mem[i] = 32'(i * 3 + 2);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 2; c++) begin
        c_exp[r*2+c] = '0;
        for (int k = 0; k < 3; k++) c_exp[r*2+c] += a_mem[r*3+k] * b_mem[k*2+c];
      end

    vecs[0]  = '{1'b1, 16'h0000, 32'h0000_01FF, 32'h0};
    vecs[1]  = '{1'b0, 16'h0000, 32'h0,         32'h0000_00FF};
    vecs[2]  = '{1'b1, 16'h0001, 32'd4,         32'h0};
    vecs[3]  = '{1'b0, 16'h0003, 32'h0,         32'd4};
    vecs[4]  = '{1'b1, 16'h0004, 32'd3,         32'h0};
    vecs[5]  = '{1'b1, 16'h0008, 32'd2,         32'h0};
    vecs[6]  = '{1'b0, 16'h0004, 32'h0,         32'd3};
    vecs[7]  = '{1'b0, 16'h0008, 32'h0,         32'd2};
    vecs[8]  = '{1'b1, 16'h0010, 32'h0000_1234, 32'h0};
    vecs[9]  = '{1'b0, 16'h0010, 32'h0,         32'h0};
    vecs[10] = '{1'b0, 16'h0FFC, 32'h0,         32'h0};
    vecs[11] = '{1'b1, 16'h1000, 32'hCAFE_0001, 32'h0};
    vecs[12] = '{1'b0, 16'h1002, 32'h0,         32'hCAFE_0001};
    vecs[13] = '{1'b1, 16'hFFFC, 32'h55AA_55AA, 32'h0};
    vecs[14] = '{1'b0, 16'hFFFC, 32'h0,         32'h55AA_55AA};
    vecs[15] = '{1'b1, 16'h2000, 32'h0BAD_F00D, 32'h0};
    vecs[16] = '{1'b0, 16'h2000, 32'h0,         32'h0BAD_F00D};

    // Reset state
    #2 rst = 1'b0;
    #1;
    check("rst_mm_run", 32'(mm_run), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rvalid", 32'(h_rvalid), 32'd0);
    check("rst_h_rdata", h_rdata, 32'd0);
    check("rst_mm_rdata", mm_rdata, 32'd0);
    @(negedge clk); rst = 1'b1;

    // Address map through the host port
    for (int i = 0; i < 17; i++)
      host_acc($sformatf("vec%0d", i), vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].exp, w);

    for (int i = 0; i < 12; i++) host_acc("load_a", 1'b1, A_B + 16'(4 * i), a_mem[i], '0, w);
    for (int i = 0; i < 6; i++)  host_acc("load_b", 1'b1, B_B + 16'(4 * i), b_mem[i], '0, w);

    // Normal run: start with a simultaneous host read, host then blocked until DONE
    run_snap = run_total;
    @(negedge clk);
    h_req = 1'b1; h_wen = 1'b0; h_addr = 16'h0004; h_start = 1'b1;
    #1;
    check("start_same_cycle_ready", 32'(h_ready), 32'd1);
    exp_q.push_back(32'd3);
    rv_expected++;
    @(posedge clk); #1;
    h_req = 1'b0; h_start = 1'b0;
    @(negedge clk);
    check("check_busy", 32'(busy), 32'd1);
    check("check_no_run", 32'(mm_run), 32'd0);
    check("start_read_rvalid", 32'(h_rvalid), 32'd1);
    check("start_read_data", h_rdata, exp_q.pop_front());
    fork
      accel_run(50, 1'b0, 2'd0);
      begin
        host_acc("blocked_read_rowa", 1'b0, 16'h0000, '0, 32'd4, w);
        check("host_blocked_cycles", 32'(w), 32'd50);
      end
    join
    check("run_length", 32'(run_total - run_snap), 32'd50);
    for (int i = 0; i < 8; i++)
      host_acc($sformatf("c_read%0d", i), 1'b0, C_B + 16'(4 * i), '0, c_exp[i], w);
    irq_clear("clr_run");

    // Zero dimension
    host_acc("wr_cola0", 1'b1, 16'h0004, 32'd0, '0, w);
    run_snap = run_total;
    pulse_start();
    @(negedge clk);
    check("dim0_check_irq", 32'(irq), 32'd0);
    check("dim0_check_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("dim0_irq", 32'(irq), 32'd1);
    check("dim0_err", 32'(err), 32'd1);
    check("dim0_no_run", 32'(run_total - run_snap), 32'd0);
    irq_clear("clr_dim0");

    // A-region overflow
    set_dims(32'd255, 32'd255, 32'd1);
    run_snap = run_total;
    pulse_start();
    repeat (2) @(negedge clk);
    check("big_err", 32'(err), 32'd1);
    check("big_irq", 32'(irq), 32'd1);
    check("big_no_run", 32'(run_total - run_snap), 32'd0);
    irq_clear("clr_big");

    // Illegal accelerator write into A
    set_dims(32'd4, 32'd3, 32'd2);
    pulse_start();
    accel_run(20, 1'b1, 2'd3);
    host_acc("a_protected", 1'b0, 16'h2000, '0, 32'h0BAD_F00D, w);
    irq_clear("clr_badwr");

    // Timeout
    run_snap = run_total;
    pulse_start();
    repeat (TO + 10) @(negedge clk);
    check("to_run_len", 32'(run_total - run_snap), 32'(TO));
    check("to_err", 32'(err), 32'd2);
    check("to_irq", 32'(irq), 32'd1);
    check("to_mm_run", 32'(mm_run), 32'd0);
    irq_clear("clr_to");

    // Reset mid-RUN
    pulse_start();
    repeat (5) @(negedge clk);
    check("pre_rst_run", 32'(mm_run), 32'd1);
    #3 rst = 1'b0;
    #1;
    check("rst_mid_run", 32'(mm_run), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_err", 32'(err), 32'd0);
    @(negedge clk); rst = 1'b1;
    host_acc("rst_rowa", 1'b0, 16'h0000, '0, 32'd0, w);
    host_acc("rst_cola", 1'b0, 16'h0004, '0, 32'd0, w);
    host_acc("rst_colb", 1'b0, 16'h0008, '0, 32'd0, w);

    repeat (2) @(negedge clk);
    check("rvalid_count", 32'(rv_total), 32'(rv_expected));
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
